// File: rtl/divider_check_8bit.sv
// Sequential shift-add multiply-accumulate: rebuilds dividend = quotient*divisor + remainder
// one multiplier bit per cycle and flags operand sets that no valid division could produce.
module divider_check_8bit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               strt,
    input  logic [WIDTH-1:0]   quotient,
    input  logic [WIDTH-1:0]   divisor,
    input  logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] dividend,
    output logic               overflow,
    output logic               not_valid,
    output logic               idle
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   dividend_q, dividend_d;
    logic                 overflow_q, overflow_d;
    logic                 not_valid_q, not_valid_d;
    logic [2*WIDTH-1:0]   sum;

    // Worst case (2^W-1)^2 + (2^W-1) fits in 2*W bits, so the accumulator never carries out.
    always_comb begin
        sum         = acc_q + (mplier_q[0] ? mcand_q : '0);
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        dividend_d  = dividend_q;
        overflow_d  = overflow_q;
        not_valid_d = not_valid_q;
        case (state_q)
            IDLE: begin
                if (strt) begin
                    mcand_d     = {{WIDTH{1'b0}}, quotient};
                    mplier_d    = divisor;
                    acc_d       = {{WIDTH{1'b0}}, remainder};
                    cnt_d       = '0;
                    not_valid_d = (divisor == '0) | (remainder >= divisor);
                    state_d     = CALC;
                end
            end
            CALC: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    dividend_d = sum;
                    overflow_d = |sum[2*WIDTH-1:WIDTH];
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            dividend_q  <= '0;
            overflow_q  <= 1'b0;
            not_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            dividend_q  <= dividend_d;
            overflow_q  <= overflow_d;
            not_valid_q <= not_valid_d;
        end
    end

    // idle doubles as the observable FSM state: 1 = IDLE, 0 = CALC.
    assign idle      = (state_q == IDLE);
    assign dividend  = dividend_q;
    assign overflow  = overflow_q;
    assign not_valid = not_valid_q;

endmodule
